// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: FSM state encoding and a
// constant-evaluable ceiling log2 used to size the beat counters.
package fifo_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } readerState_e;

   // Smallest number of bits able to count value distinct states.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order output buffer; the head entry always drives the stream.
// A push while full or a pop while empty is ignored, so it can never overflow.
module stream_skid_buf2 #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [1:0]   count_o,
   output logic [W-1:0] head_o
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   count_q, count_d;
   logic         doPush;
   logic         doPop;

   assign doPush  = push_i && (count_q != 2'd2);
   assign doPop   = pop_i && (count_q != 2'd0);
   assign count_o = count_q;
   assign head_o  = head_q;

   // With one entry, simultaneous push and pop replaces the head in place,
   // which keeps the occupancy constant and preserves word order.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (doPush) begin
               head_d  = din_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            case ({doPush, doPop})
               2'b10: begin
                  tail_d  = din_i;
                  count_d = 2'd2;
               end
               2'b01: count_d = 2'd0;
               2'b11: head_d = din_i;
               default: ;
            endcase
         end
         2'd2: begin
            if (doPop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads fixed-length bursts from a first-word-fall-through FIFO and presents
// them as a valid/ready stream; a burst once started is always completed.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter  int FIFO_DATAWIDTH = 16,
   parameter  int BURST_LEN      = 8,
   localparam int BEAT_W         = clog2(BURST_LEN)
) (
   input  logic                      rd_clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      fifo_empty,
   input  logic [FIFO_DATAWIDTH-1:0] fifo_dout,
   output logic                      fifo_rd_en,
   output logic [FIFO_DATAWIDTH-1:0] m_data,
   output logic                      m_valid,
   output logic                      m_last,
   input  logic                      m_ready,
   output logic                      busy,
   output logic [BEAT_W-1:0]         beat_cnt
);

   localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BURST_LEN - 1);

   readerState_e      state_q, state_d;
   logic [BEAT_W-1:0] rdCnt_q, rdCnt_d;
   logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
   logic [1:0]        bufCount;
   logic              fetchOk;
   logic              handshake;

   // Popped words go straight into the buffer at the next edge, so the pop
   // decision depends only on buffer occupancy, never on m_ready.
   stream_skid_buf2 #(
      .W(FIFO_DATAWIDTH)
   ) outBuf (
      .clk_i  (rd_clk),
      .rst_ni (rst_n),
      .push_i (fifo_rd_en),
      .pop_i  (handshake),
      .din_i  (fifo_dout),
      .count_o(bufCount),
      .head_o (m_data)
   );

   assign fetchOk    = (state_q == RUN) || ((state_q == STOP) && (rdCnt_q != '0));
   assign fifo_rd_en = !fifo_empty && (bufCount < 2'd2) && fetchOk;
   assign m_valid    = (bufCount != 2'd0);
   assign handshake  = m_valid && m_ready;
   assign m_last     = m_valid && (beatCnt_q == LastBeat);
   assign busy       = (state_q != IDLE);
   assign beat_cnt   = beatCnt_q;

   // Leaving RUN straight for IDLE also requires no pop in this very cycle;
   // otherwise a freshly started burst would be stranded with fetching off.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) begin
               if ((rdCnt_q == '0) && (bufCount == 2'd0) && !fifo_rd_en) state_d = IDLE;
               else state_d = STOP;
            end
         end
         STOP: begin
            if (enable) state_d = RUN;
            else if ((rdCnt_q == '0) && (bufCount == 2'd0) && !handshake) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdCnt_d   = rdCnt_q;
      beatCnt_d = beatCnt_q;
      if (fifo_rd_en) rdCnt_d = (rdCnt_q == LastBeat) ? '0 : rdCnt_q + 1'b1;
      if (handshake) beatCnt_d = (beatCnt_q == LastBeat) ? '0 : beatCnt_q + 1'b1;
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rdCnt_q   <= '0;
         beatCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rdCnt_q   <= rdCnt_d;
         beatCnt_q <= beatCnt_d;
      end
   end

endmodule
